// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-back, write-allocate data cache
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic [3:0]          cpu_be,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [32*WORDS-1:0] mem_wline,
  input  logic [32*WORDS-1:0] mem_rline,
  input  logic                mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WORD_W = $clog2(WORDS);
  localparam int SET_W  = $clog2(SETS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - OFF_W - SET_W;

  localparam logic [1:0] S_LOOKUP    = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS][WORDS];

  logic [1:0]       state_q;
  logic [WAY_W-1:0] victim_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [SET_W-1:0] miss_set_q;
  logic             after_miss_q;

  logic [SET_W-1:0]  set_idx;
  logic [WORD_W-1:0] word_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              cpu_req;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim_sel;
  logic              victim_dirty;
  logic              lookup_hit;
  logic              lookup_miss;
  logic [WAY_W-1:0]  rr_next;
  logic              unused_addr;

  assign set_idx     = cpu_addr[OFF_W +: SET_W];
  assign word_idx    = cpu_addr[2 +: WORD_W];
  assign addr_tag    = cpu_addr[31 -: TAG_W];
  assign cpu_req     = cpu_rd | cpu_wr;
  assign unused_addr = ^cpu_addr[1:0];

  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[set_idx][i] && tag_q[set_idx][i] == addr_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
    // Scan downward so the lowest-index invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[set_idx][i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
  end

  assign victim_sel   = inv_found ? inv_way : rr_q[set_idx];
  assign victim_dirty = !inv_found && dirty_q[set_idx][victim_sel];
  assign rr_next      = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
  assign lookup_hit   = (state_q == S_LOOKUP) && cpu_req && hit_any;
  assign lookup_miss  = (state_q == S_LOOKUP) && cpu_req && !hit_any;

  // Outputs are forced quiet while reset is held, even with a request present.
  assign cpu_stall = RESET_N && cpu_req && !lookup_hit;
  assign cpu_rdata = (RESET_N && cpu_rd && lookup_hit) ? data_q[set_idx][hit_way][word_idx] : 32'd0;
  assign mem_req   = (state_q == S_WRITEBACK) || (state_q == S_REFILL);
  assign mem_we    = (state_q == S_WRITEBACK);

  always_comb begin
    mem_addr = 32'd0;
    case (state_q)
      S_WRITEBACK: mem_addr = {tag_q[miss_set_q][victim_q], miss_set_q, {OFF_W{1'b0}}};
      S_REFILL:    mem_addr = {miss_tag_q, miss_set_q, {OFF_W{1'b0}}};
      default:     mem_addr = 32'd0;
    endcase
  end

  always_comb begin
    mem_wline = '0;
    for (int w = 0; w < WORDS; w++) begin
      mem_wline[32*w +: 32] = data_q[miss_set_q][victim_q][w];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_LOOKUP;
      victim_q     <= '0;
      miss_tag_q   <= '0;
      miss_set_q   <= '0;
      after_miss_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        S_LOOKUP: begin
          after_miss_q <= 1'b0;
          if (lookup_hit && cpu_wr) begin
            dirty_q[set_idx][hit_way] <= 1'b1;
          end
          if (lookup_miss) begin
            // Miss line is latched so a dropped request cannot redirect the refill.
            victim_q   <= victim_sel;
            miss_tag_q <= addr_tag;
            miss_set_q <= set_idx;
            if (!inv_found) begin
              rr_q[set_idx] <= rr_next;
            end
            state_q <= victim_dirty ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            valid_q[miss_set_q][victim_q] <= 1'b1;
            dirty_q[miss_set_q][victim_q] <= 1'b0;
            after_miss_q                  <= 1'b1;
            state_q                       <= S_LOOKUP;
          end
        end
        default: state_q <= S_LOOKUP;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_REFILL && mem_ack) begin
      tag_q[miss_set_q][victim_q] <= miss_tag_q;
      for (int w = 0; w < WORDS; w++) begin
        data_q[miss_set_q][victim_q][w] <= mem_rline[32*w +: 32];
      end
    end else if (lookup_hit && cpu_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be[b]) begin
          data_q[set_idx][hit_way][word_idx][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // The hit that finishes a miss belongs to that miss, not to the hit count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (lookup_hit && !after_miss_q && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (lookup_miss && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// tb/tb_dcache_nway.sv - directed self-checking bench for dcache_nway
// Stats checks are included when DCACHE_STATS_EN is defined.
module tb_dcache_nway;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         cpu_rd, cpu_wr;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wline, mem_rline;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 CLK = ~CLK;

  dcache_nway #(.WAYS(2), .SETS(16), .WORDS(4)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wline (mem_wline),
    .mem_rline (mem_rline),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = addr; cpu_wdata = data; cpu_be = be;
    #1;
  endtask

  task automatic ack_cycle(input logic [127:0] line);
    mem_rline = line;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    #1;
  endtask

  // Miss with a clean victim, refilled with ack in the first REFILL cycle.
  task automatic miss_fill(input string tag, input logic [31:0] addr, input logic [127:0] line);
    check({tag, "_miss_stall"}, 128'(cpu_stall), 128'd1);
    tick();
    check({tag, "_req"}, 128'(mem_req), 128'd1);
    check({tag, "_we"}, 128'(mem_we), 128'd0);
    check({tag, "_addr"}, 128'(mem_addr), 128'(addr & 32'hFFFF_FFF0));
    ack_cycle(line);
    check({tag, "_done_stall"}, 128'(cpu_stall), 128'd0);
  endtask

  localparam logic [127:0] L1 = {32'hD, 32'hC, 32'hB, 32'hA};
  localparam logic [127:0] L0 = {32'h13, 32'h12, 32'h11, 32'h10};
  localparam logic [127:0] L2 = {32'h23, 32'h22, 32'h21, 32'h20};
  localparam logic [127:0] L3 = {32'h33, 32'h32, 32'h31, 32'h30};
  localparam logic [127:0] L4 = {32'h43, 32'h42, 32'h41, 32'h40};
  localparam logic [127:0] L5 = {32'h53, 32'h52, 32'h51, 32'h50};

  initial begin
    RESET_N = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100; cpu_wdata = '0; cpu_be = '0;
    mem_rline = '0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_stall", 128'(cpu_stall), 128'd0);
    check("rst_rdata", 128'(cpu_rdata), 128'd0);
    check("rst_req", 128'(mem_req), 128'd0);
    check("rst_we", 128'(mem_we), 128'd0);
    check("rst_addr", 128'(mem_addr), 128'd0);

    // Cold read, ack three cycles after request rises.
    RESET_N = 1'b1;
    rd(32'h100);
    check("cold_stall", 128'(cpu_stall), 128'd1);
    check("cold_noreq", 128'(mem_req), 128'd0);
    tick();
    check("cold_req", 128'(mem_req), 128'd1);
    check("cold_we", 128'(mem_we), 128'd0);
    check("cold_addr", 128'(mem_addr), 128'h100);
    tick(); tick();
    check("cold_wait_stall", 128'(cpu_stall), 128'd1);
    ack_cycle(L1);
    check("cold_hit_stall", 128'(cpu_stall), 128'd0);
    check("cold_rdata", 128'(cpu_rdata), 128'hA);
    check("cold_req_drop", 128'(mem_req), 128'd0);
    tick();
    rd(32'h10C);
    check("hit_10c_rdata", 128'(cpu_rdata), 128'hD);
    check("hit_10c_req", 128'(mem_req), 128'd0);
    tick();
    rd(32'h108);
    check("hit_108_rdata", 128'(cpu_rdata), 128'hC);
    tick();
`ifdef DCACHE_STATS_EN
    check("stats_hit", 128'(hit_cnt), 128'd2);
    check("stats_miss", 128'(miss_cnt), 128'd1);
`endif

    // Byte-enable store hit.
    wr(32'h104, 32'h1111_1111, 4'hF);
    check("st_full_stall", 128'(cpu_stall), 128'd0);
    tick();
    wr(32'h104, 32'hAABB_CCDD, 4'b0011);
    check("st_byte_stall", 128'(cpu_stall), 128'd0);
    tick();
    rd(32'h104);
    check("st_byte_rdata", 128'(cpu_rdata), 128'h1111_CCDD);
    rd(32'h100);
    check("st_neighbor", 128'(cpu_rdata), 128'hA);
    tick();

    cpu_rd = 1'b0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;

    // Dirty eviction: way0 holds 0x000 (stored), way1 holds 0x100.
    rd(32'h000);
    miss_fill("fill000", 32'h000, L0);
    tick();
    rd(32'h100);
    miss_fill("fill100", 32'h100, L2);
    tick();
    wr(32'h000, 32'hCAFE_F00D, 4'hF);
    check("dirty_st_stall", 128'(cpu_stall), 128'd0);
    tick();
    rd(32'h200);
    check("ev_stall", 128'(cpu_stall), 128'd1);
    tick();
    check("wb_req", 128'(mem_req), 128'd1);
    check("wb_we", 128'(mem_we), 128'd1);
    check("wb_addr", 128'(mem_addr), 128'h000);
    check("wb_line", mem_wline, {32'h13, 32'h12, 32'h11, 32'hCAFE_F00D});
    tick();
    check("wb_hold_we", 128'(mem_we), 128'd1);
    check("wb_hold_addr", 128'(mem_addr), 128'h000);
    ack_cycle('0);
    check("ev_rf_we", 128'(mem_we), 128'd0);
    check("ev_rf_addr", 128'(mem_addr), 128'h200);
    ack_cycle(L3);
    check("ev_rdata", 128'(cpu_rdata), 128'h30);
    tick();
    rd(32'h100);
    check("ev_keep_stall", 128'(cpu_stall), 128'd0);
    check("ev_keep_rdata", 128'(cpu_rdata), 128'h20);
    tick();

    // Clean eviction: round-robin now selects way1 (0x100, clean).
    rd(32'h300);
    miss_fill("clean", 32'h300, L4);
    check("clean_rdata", 128'(cpu_rdata), 128'h40);
    tick();
    rd(32'h204);
    check("clean_keep_rdata", 128'(cpu_rdata), 128'h31);
    tick();

    // Reset during REFILL drops the request at once.
    rd(32'h100);
    check("rr_miss_stall", 128'(cpu_stall), 128'd1);
    tick();
    check("rr_req", 128'(mem_req), 128'd1);
    tick();
    RESET_N = 1'b0;
    #1;
    check("mid_rst_req", 128'(mem_req), 128'd0);
    check("mid_rst_stall", 128'(cpu_stall), 128'd0);
    tick();
    RESET_N = 1'b1;
    #1;
    miss_fill("post_rst", 32'h100, L2);
    check("post_rst_rdata", 128'(cpu_rdata), 128'h20);
    tick();

    // Store miss merges on the hit cycle after refill.
    wr(32'h014, 32'h5A5A_5A5A, 4'hF);
    miss_fill("st_miss", 32'h010, L5);
    tick();
    rd(32'h014);
    check("st_miss_rdata", 128'(cpu_rdata), 128'h5A5A_5A5A);
    rd(32'h018);
    check("st_miss_other", 128'(cpu_rdata), 128'h52);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
